// File: rtl/instr_sequencer.sv
// Control FSM for a simple register-machine datapath: decodes the latched
// opcode/op fields and steps the datapath strobes through each instruction.
module instr_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [3:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       illegal
);

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        GET_A,
        GET_B,
        EXEC,
        COMPARE,
        WR_REG,
        WR_IMM
    } state_t;

    state_t     r_state;
    logic [2:0] r_opcode;
    logic [1:0] r_op;

    logic w_isMovImm;
    logic w_isMovReg;
    logic w_isAlu;
    logic w_isCmp;
    logic w_isMvn;
    logic w_aselMov;

    assign w_isMovImm = (r_opcode == 3'b110) && (r_op == 2'b10);
    assign w_isMovReg = (r_opcode == 3'b110) && (r_op == 2'b00);
    assign w_isAlu    = (r_opcode == 3'b101);
    assign w_isCmp    = w_isAlu && (r_op == 2'b01);
    assign w_isMvn    = w_isAlu && (r_op == 2'b11);
    assign w_aselMov  = w_isMovReg || w_isMvn;

    // Outputs are computed for the state being entered, so they are registered
    // yet always line up with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= WAIT;
            r_opcode <= '0;
            r_op     <= '0;
            w        <= 1'b1;
            illegal  <= 1'b0;
            nsel     <= '0;
            vsel     <= '0;
            write    <= 1'b0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            loadc    <= 1'b0;
            loads    <= 1'b0;
            asel     <= 1'b0;
            bsel     <= 1'b0;
        end else begin
            w       <= 1'b0;
            illegal <= 1'b0;
            nsel    <= '0;
            vsel    <= '0;
            write   <= 1'b0;
            loada   <= 1'b0;
            loadb   <= 1'b0;
            loadc   <= 1'b0;
            loads   <= 1'b0;
            asel    <= 1'b0;
            bsel    <= 1'b0;
            case (r_state)
                WAIT: begin
                    if (s) begin
                        r_opcode <= opcode;
                        r_op     <= op;
                        r_state  <= DECODE;
                    end else begin
                        w <= 1'b1;
                    end
                end
                DECODE: begin
                    if (w_isMovImm) begin
                        r_state <= WR_IMM;
                        nsel    <= 3'b100;
                        vsel    <= 4'b0100;
                        write   <= 1'b1;
                    end else if (w_isMovReg || w_isMvn) begin
                        r_state <= GET_B;
                        nsel    <= 3'b001;
                        loadb   <= 1'b1;
                    end else if (w_isAlu) begin
                        r_state <= GET_A;
                        nsel    <= 3'b100;
                        loada   <= 1'b1;
                    end else begin
                        r_state <= WAIT;
                        w       <= 1'b1;
                        illegal <= 1'b1;
                    end
                end
                GET_A: begin
                    r_state <= GET_B;
                    nsel    <= 3'b001;
                    loadb   <= 1'b1;
                end
                GET_B: begin
                    if (w_isCmp) begin
                        r_state <= COMPARE;
                        loads   <= 1'b1;
                    end else begin
                        r_state <= EXEC;
                        loadc   <= 1'b1;
                        asel    <= w_aselMov;
                    end
                end
                EXEC: begin
                    r_state <= WR_REG;
                    nsel    <= 3'b010;
                    vsel    <= 4'b0001;
                    write   <= 1'b1;
                end
                default: begin
                    r_state <= WAIT;
                    w       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random instruction streams,
// each checked cycle by cycle against a per-instruction-class output table.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       illegal;

    int assertCount = 0;
    int failCount   = 0;

    logic [15:0] expQ[$];

    instr_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .s       (s),
        .opcode  (opcode),
        .op      (op),
        .w       (w),
        .nsel    (nsel),
        .vsel    (vsel),
        .write   (write),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic wv, input logic ill,
                                       input logic [2:0] ns, input logic [3:0] vs,
                                       input logic wr, input logic la, input logic lb,
                                       input logic lc, input logic ls, input logic as);
        return {wv, ill, ns, vs, wr, la, lb, lc, ls, as, 1'b0};
    endfunction

    localparam logic [15:0] IDLE = 16'h8000;

    // Expected outputs for each cycle after the start edge, by instruction class.
    task automatic buildExpected(input logic [2:0] opc, input logic [1:0] opv);
        expQ.delete();
        expQ.push_back(16'h0000);
        if (opc == 3'b110 && opv == 2'b10) begin
            expQ.push_back(mk(0, 0, 3'b100, 4'b0100, 1, 0, 0, 0, 0, 0));
            expQ.push_back(IDLE);
        end else if ((opc == 3'b110 && opv == 2'b00) || (opc == 3'b101 && opv == 2'b11)) begin
            expQ.push_back(mk(0, 0, 3'b001, 4'b0000, 0, 0, 1, 0, 0, 0));
            expQ.push_back(mk(0, 0, 3'b000, 4'b0000, 0, 0, 0, 1, 0, 1));
            expQ.push_back(mk(0, 0, 3'b010, 4'b0001, 1, 0, 0, 0, 0, 0));
            expQ.push_back(IDLE);
        end else if (opc == 3'b101 && opv == 2'b01) begin
            expQ.push_back(mk(0, 0, 3'b100, 4'b0000, 0, 1, 0, 0, 0, 0));
            expQ.push_back(mk(0, 0, 3'b001, 4'b0000, 0, 0, 1, 0, 0, 0));
            expQ.push_back(mk(0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 1, 0));
            expQ.push_back(IDLE);
        end else if (opc == 3'b101) begin
            expQ.push_back(mk(0, 0, 3'b100, 4'b0000, 0, 1, 0, 0, 0, 0));
            expQ.push_back(mk(0, 0, 3'b001, 4'b0000, 0, 0, 1, 0, 0, 0));
            expQ.push_back(mk(0, 0, 3'b000, 4'b0000, 0, 0, 0, 1, 0, 0));
            expQ.push_back(mk(0, 0, 3'b010, 4'b0001, 1, 0, 0, 0, 0, 0));
            expQ.push_back(IDLE);
        end else begin
            expQ.push_back(mk(1, 1, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] expected);
        logic [15:0] observed;
        observed = {w, illegal, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel};
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // mode: 0 holds inputs, 1 switches to MOV imm after start, 2 randomizes them.
    task automatic applyStimulus(input string name, input logic [2:0] opc,
                                 input logic [1:0] opv, input bit idleAfter, input int mode);
        opcode = opc;
        op     = opv;
        s      = 1'b1;
        buildExpected(opc, opv);
        for (int i = 0; i < expQ.size(); i++) begin
            step();
            checkOutput($sformatf("%s cycle%0d", name, i + 1), expQ[i]);
            if (i < expQ.size() - 1) begin
                if (mode == 1) begin
                    opcode = 3'b110;
                    op     = 2'b10;
                end else if (mode == 2) begin
                    opcode = 3'($urandom);
                    op     = 2'($urandom);
                    s      = 1'($urandom);
                end else begin
                    s = 1'b0;
                end
            end
        end
        if (idleAfter) begin
            s = 1'b0;
            step();
            checkOutput($sformatf("%s idle", name), IDLE);
        end
    endtask

    initial begin
        logic [4:0] legal [6];
        logic [4:0] pick;
        legal = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};
        $display("[TB] instr_sequencer bench start");

        reset  = 1'b1;
        s      = 1'b0;
        opcode = 3'b000;
        op     = 2'b00;
        step();
        step();
        checkOutput("reset", IDLE);
        reset = 1'b0;
        step();
        checkOutput("idle after reset", IDLE);

        applyStimulus("movImm", 3'b110, 2'b10, 1'b1, 0);
        applyStimulus("add", 3'b101, 2'b00, 1'b1, 0);
        applyStimulus("cmp", 3'b101, 2'b01, 1'b1, 0);
        applyStimulus("mvnLatched", 3'b101, 2'b11, 1'b1, 1);
        applyStimulus("movReg", 3'b110, 2'b00, 1'b1, 0);
        applyStimulus("and", 3'b101, 2'b10, 1'b1, 0);
        applyStimulus("illegal000", 3'b000, 2'b00, 1'b1, 0);
        applyStimulus("illegal110/11", 3'b110, 2'b11, 1'b1, 0);

        applyStimulus("b2bMovImm", 3'b110, 2'b10, 1'b0, 0);
        applyStimulus("b2bIllegal", 3'b111, 2'b01, 1'b0, 0);
        applyStimulus("b2bCmp", 3'b101, 2'b01, 1'b1, 0);

        // Abort an ADD while it sits in GET_B, with s still requested.
        opcode = 3'b101;
        op     = 2'b00;
        s      = 1'b1;
        buildExpected(3'b101, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("abortAdd cycle%0d", i + 1), expQ[i]);
        end
        reset = 1'b1;
        step();
        checkOutput("abortAdd reset edge", IDLE);
        reset = 1'b0;
        s     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("abortAdd after%0d", i), IDLE);
        end

        reset  = 1'b1;
        s      = 1'b1;
        opcode = 3'b110;
        op     = 2'b10;
        step();
        checkOutput("resetBeatsStart", IDLE);
        reset = 1'b0;
        s     = 1'b0;
        step();
        checkOutput("resetBeatsStart idle", IDLE);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                pick = legal[$urandom_range(0, 5)];
            end else begin
                pick = 5'($urandom);
            end
            applyStimulus($sformatf("rand%0d_%b", n, pick), pick[4:2], pick[1:0],
                          1'($urandom), 2);
        end
        s = 1'b0;
        step();
        checkOutput("final idle", IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
